tlul_sram_responder: RTL and testbench

TLUL_SRAM_RESPONDER -- requirements
Module: tlul_sram_responder

---
 rtl/tlul_pkg.sv | 49 ++++
 rtl/tlul_sram_rsp_fifo.sv | 109 ++++++++++
 rtl/tlul_sram_responder.sv | 118 +++++++++++
 tb/tb_tlul_sram_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL opcode enums, bus widths and the host->device /
// device->host channel structs shared by TL-UL agents.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;  // address width
    localparam int unsigned TL_DW  = 32;  // data width
    localparam int unsigned TL_DBW = 4;   // byte lanes
    localparam int unsigned TL_SZW = 2;   // a_size / d_size width
    localparam int unsigned TL_AIW = 8;   // source id width
    localparam int unsigned TL_DIW = 1;   // sink id width
    localparam int unsigned TL_DUW = 8;   // d_user width

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_rsp_fifo.sv
// tlul_sram_rsp_fifo: in-order response entry store for the SRAM responder.
// Holds Depth entries {get, size, source, err, data}, the occupancy count and
// the one-cycle-late SRAM read-data capture.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   i_push / i_push_*   new entry from an accepted A beat
//   i_rdata             SRAM read data (valid the cycle after a read strobe)
//   i_pop               D-channel ready; pops the head when o_valid
//   o_full              count == Depth
//   o_valid / o_*       head entry, eligible once its read data is present
module tlul_sram_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned SrcW  = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_push,
    input  logic            i_push_get,
    input  logic [1:0]      i_push_size,
    input  logic [SrcW-1:0] i_push_source,
    input  logic            i_push_err,
    input  logic [31:0]     i_rdata,
    input  logic            i_pop,
    output logic            o_full,
    output logic            o_valid,
    output logic            o_get,
    output logic [1:0]      o_size,
    output logic [SrcW-1:0] o_source,
    output logic            o_err,
    output logic [31:0]     o_data
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic            r_get    [Depth];
    logic [1:0]      r_size   [Depth];
    logic [SrcW-1:0] r_source [Depth];
    logic            r_err    [Depth];
    logic [31:0]     r_data   [Depth];
    logic            r_rdy    [Depth];

    logic [PtrW-1:0] r_wr, r_rd, r_cap_idx;
    logic [CntW-1:0] r_cnt;
    logic            r_cap_pend;

    logic [PtrW-1:0] w_wr_nxt, w_rd_nxt;
    logic            w_head_cap, w_pop;

    assign w_wr_nxt = (r_wr == PtrW'(Depth - 1)) ? '0 : r_wr + 1'b1;
    assign w_rd_nxt = (r_rd == PtrW'(Depth - 1)) ? '0 : r_rd + 1'b1;

    // Head whose read data arrives this cycle is forwarded straight from the
    // SRAM so an empty FIFO answers a Get with one cycle of latency.
    assign w_head_cap = r_cap_pend && (r_cap_idx == r_rd);
    assign o_valid    = (r_cnt != '0) && (r_rdy[r_rd] || w_head_cap);
    assign o_data     = w_head_cap ? i_rdata : r_data[r_rd];
    assign o_get      = r_get[r_rd];
    assign o_size     = r_size[r_rd];
    assign o_source   = r_source[r_rd];
    assign o_err      = r_err[r_rd];
    assign o_full     = (r_cnt == CntW'(Depth));
    assign w_pop      = i_pop && o_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_cap_pend <= 1'b0;
            r_cap_idx  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                r_get[i]    <= 1'b0;
                r_size[i]   <= '0;
                r_source[i] <= '0;
                r_err[i]    <= 1'b0;
                r_data[i]   <= '0;
                r_rdy[i]    <= 1'b0;
            end
        end else begin
            // Capture is written before the push so that a push reusing a
            // just-freed slot wins over a late capture into that slot.
            if (r_cap_pend) begin
                r_data[r_cap_idx] <= i_rdata;
                r_rdy[r_cap_idx]  <= 1'b1;
            end
            if (i_push) begin
                r_get[r_wr]    <= i_push_get;
                r_size[r_wr]   <= i_push_size;
                r_source[r_wr] <= i_push_source;
                r_err[r_wr]    <= i_push_err;
                r_data[r_wr]   <= '0;
                r_rdy[r_wr]    <= !(i_push_get && !i_push_err);
                r_wr           <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd <= w_rd_nxt;
            end
            r_cap_pend <= i_push && i_push_get && !i_push_err;
            r_cap_idx  <= r_wr;
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/tlul_sram_responder.sv
// tlul_sram_responder: TL-UL device adapter onto a single-port SRAM with
// one-cycle read latency. Checks each A beat, strobes the SRAM for legal
// beats and answers every beat in order through tlul_sram_rsp_fifo.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   tl_i / tl_o    TL-UL host->device / device->host channels
//   req_o, we_o    SRAM strobe and write enable
//   addr_o         SRAM word address (a_address[SramAw+1:2])
//   wdata_o        SRAM write data
//   wmask_o        SRAM bit mask (byte mask replicated per bit)
//   rdata_i        SRAM read data, one cycle after a read strobe
module tlul_sram_responder
    import tlul_pkg::*;
#(
    parameter int unsigned SramAw      = 12,
    parameter int unsigned Outstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              req_o,
    output logic              we_o,
    output logic [SramAw-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       wmask_o,
    input  logic [31:0]       rdata_i
);

    typedef struct packed {
        logic opcode;
        logic size;
        logic align;
        logic mask;
    } chk_t;

    chk_t              w_chk;
    logic [3:0]        w_exp_mask;
    logic              w_err, w_is_get, w_a_ready, w_accept, w_full;
    logic              w_rsp_valid, w_rsp_get, w_rsp_err;
    logic [1:0]        w_rsp_size;
    logic [TL_AIW-1:0] w_rsp_source;
    logic [31:0]       w_rsp_data;
    logic              w_unused;

    // Upper address bits are decoded by the crossbar.
    assign w_unused = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:SramAw+2]};

    always_comb begin
        w_chk        = '0;
        w_exp_mask   = '0;
        w_chk.opcode = !(tl_i.a_opcode inside {Get, PutFullData, PutPartialData});
        w_chk.size   = (tl_i.a_size > 2'd2);
        case (tl_i.a_size)
            2'd0: w_exp_mask = 4'b0001 << tl_i.a_address[1:0];
            2'd1: begin
                w_chk.align = tl_i.a_address[0];
                w_exp_mask  = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_chk.align = |tl_i.a_address[1:0];
                w_exp_mask  = 4'b1111;
            end
        endcase
        w_chk.mask = (tl_i.a_opcode == PutFullData) && (tl_i.a_mask != w_exp_mask);
    end

    assign w_err     = |w_chk;
    assign w_is_get  = (tl_i.a_opcode == Get);
    assign w_a_ready = !rst_i && !w_full;
    assign w_accept  = tl_i.a_valid && w_a_ready;

    assign req_o   = w_accept && !w_err;
    assign we_o    = req_o && !w_is_get;
    assign addr_o  = tl_i.a_address[SramAw+1:2];
    assign wdata_o = tl_i.a_data;

    always_comb begin
        wmask_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
        end
    end

    tlul_sram_rsp_fifo #(
        .Depth (Outstanding),
        .SrcW  (TL_AIW)
    ) u_rsp_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i_push        (w_accept),
        .i_push_get    (w_is_get),
        .i_push_size   (tl_i.a_size),
        .i_push_source (tl_i.a_source),
        .i_push_err    (w_err),
        .i_rdata       (rdata_i),
        .i_pop         (tl_i.d_ready),
        .o_full        (w_full),
        .o_valid       (w_rsp_valid),
        .o_get         (w_rsp_get),
        .o_size        (w_rsp_size),
        .o_source      (w_rsp_source),
        .o_err         (w_rsp_err),
        .o_data        (w_rsp_data)
    );

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = w_rsp_valid && !rst_i;
        tl_o.d_opcode = w_rsp_get ? AccessAckData : AccessAck;
        tl_o.d_size   = w_rsp_size;
        tl_o.d_source = w_rsp_source;
        tl_o.d_data   = w_rsp_data;
        tl_o.d_error  = w_rsp_err;
        tl_o.a_ready  = w_a_ready;
    end

endmodule

// File: tb/tb_tlul_sram_responder.sv
module tb_tlul_sram_responder;
    import tlul_pkg::*;

    logic        clk;
    logic        rst_i;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        req_o, we_o;
    logic [11:0] addr_o;
    logic [31:0] wdata_o, wmask_o, rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    tlul_sram_responder #(
        .SramAw      (12),
        .Outstanding (2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .req_o   (req_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .wmask_o (wmask_o),
        .rdata_i (rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM stand-in: word 4 holds 0xDEADBEEF, others 0xC0DE0000 | word address.
    function automatic logic [31:0] sram_word(input logic [11:0] a);
        return (a == 12'h004) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
    endfunction

    always @(posedge clk) begin
        if (req_o && !we_o) rdata_i <= sram_word(addr_o);
        else                rdata_i <= 32'hBAD0BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(op);
        tl_i.a_param   = 3'd0;
        tl_i.a_size    = sz;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
    endtask

    initial begin
        rst_i = 1'b1;
        tl_i  = '0;
        tl_i.d_ready = 1'b1;
        drive_a(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3);
        cyc(); #1;
        chk("rst_a_ready", 32'(tl_o.a_ready), 32'd0);
        chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("rst_req", 32'(req_o), 32'd0);
        cyc();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("post_rst_a_ready", 32'(tl_o.a_ready), 32'd1);
        chk("post_rst_d_valid", 32'(tl_o.d_valid), 32'd0);

        // Get 0x10 -> word 4
        cyc(); drive_a(3'd4, 2'd2, 32'h0000_0010, 4'hF, 32'h0, 8'd3); #1;
        chk("get_req", 32'(req_o), 32'd1);
        chk("get_we", 32'(we_o), 32'd0);
        chk("get_addr", 32'(addr_o), 32'h004);
        chk("get_no_same_cycle_d", 32'(tl_o.d_valid), 32'd0);
        cyc(); tl_i.a_valid = 1'b0; #1;
        chk("get_d_valid", 32'(tl_o.d_valid), 32'd1);
        chk("get_d_opcode", 32'(tl_o.d_opcode), 32'd1);
        chk("get_d_data", tl_o.d_data, 32'hDEADBEEF);
        chk("get_d_source", 32'(tl_o.d_source), 32'd3);
        chk("get_d_size", 32'(tl_o.d_size), 32'd2);
        chk("get_d_error", 32'(tl_o.d_error), 32'd0);
        chk("get_d_zero_fields", 32'({tl_o.d_param, tl_o.d_sink, tl_o.d_user}), 32'd0);

        // PutPartialData 0x8, mask 0110
        cyc(); drive_a(3'd1, 2'd2, 32'h8, 4'b0110, 32'h11223344, 8'd5); #1;
        chk("get_popped", 32'(tl_o.d_valid), 32'd0);
        chk("ppd_req", 32'(req_o), 32'd1);
        chk("ppd_we", 32'(we_o), 32'd1);
        chk("ppd_wmask", wmask_o, 32'h00FFFF00);
        chk("ppd_wdata", wdata_o, 32'h11223344);
        chk("ppd_addr", 32'(addr_o), 32'h002);

        // Misaligned word Get at 0x2
        cyc(); drive_a(3'd4, 2'd2, 32'h2, 4'hF, 32'h0, 8'd7); #1;
        chk("ppd_d_valid", 32'(tl_o.d_valid), 32'd1);
        chk("ppd_d_opcode", 32'(tl_o.d_opcode), 32'd0);
        chk("ppd_d_error", 32'(tl_o.d_error), 32'd0);
        chk("ppd_d_data", tl_o.d_data, 32'd0);
        chk("ppd_d_source", 32'(tl_o.d_source), 32'd5);
        chk("misal_req", 32'(req_o), 32'd0);
        chk("misal_a_ready", 32'(tl_o.a_ready), 32'd1);

        // PutFullData word with partial mask
        cyc(); drive_a(3'd0, 2'd2, 32'h0, 4'b0111, 32'hAAAA5555, 8'd8); #1;
        chk("misal_d_opcode", 32'(tl_o.d_opcode), 32'd1);
        chk("misal_d_data", tl_o.d_data, 32'd0);
        chk("misal_d_error", 32'(tl_o.d_error), 32'd1);
        chk("misal_d_source", 32'(tl_o.d_source), 32'd7);
        chk("pfd_badmask_req", 32'(req_o), 32'd0);

        // Illegal opcode 2
        cyc(); drive_a(3'd2, 2'd2, 32'hC, 4'hF, 32'h0, 8'd10); #1;
        chk("pfd_badmask_d_opcode", 32'(tl_o.d_opcode), 32'd0);
        chk("pfd_badmask_d_error", 32'(tl_o.d_error), 32'd1);
        chk("pfd_badmask_d_source", 32'(tl_o.d_source), 32'd8);
        chk("illop_req", 32'(req_o), 32'd0);

        // PutFullData byte at 0x3, mask 1000
        cyc(); drive_a(3'd0, 2'd0, 32'h3, 4'b1000, 32'h5A000000, 8'd11); #1;
        chk("illop_d_opcode", 32'(tl_o.d_opcode), 32'd0);
        chk("illop_d_error", 32'(tl_o.d_error), 32'd1);
        chk("illop_d_source", 32'(tl_o.d_source), 32'd10);
        chk("pfd_byte_req", 32'(req_o), 32'd1);
        chk("pfd_byte_we", 32'(we_o), 32'd1);
        chk("pfd_byte_wmask", wmask_o, 32'hFF000000);
        chk("pfd_byte_addr", 32'(addr_o), 32'h000);

        // Get with high address bits set
        cyc(); drive_a(3'd4, 2'd2, 32'h8000_0014, 4'hF, 32'h0, 8'd9); #1;
        chk("pfd_byte_d_opcode", 32'(tl_o.d_opcode), 32'd0);
        chk("pfd_byte_d_error", 32'(tl_o.d_error), 32'd0);
        chk("pfd_byte_d_size", 32'(tl_o.d_size), 32'd0);
        chk("pfd_byte_d_source", 32'(tl_o.d_source), 32'd11);
        chk("hiaddr_req", 32'(req_o), 32'd1);
        chk("hiaddr_addr", 32'(addr_o), 32'h005);
        cyc(); tl_i.a_valid = 1'b0; #1;
        chk("hiaddr_d_opcode", 32'(tl_o.d_opcode), 32'd1);
        chk("hiaddr_d_data", tl_o.d_data, 32'hC0DE0005);
        chk("hiaddr_d_source", 32'(tl_o.d_source), 32'd9);

        // Backpressure: three Gets with d_ready low
        cyc(); tl_i.d_ready = 1'b0; drive_a(3'd4, 2'd2, 32'h20, 4'hF, 32'h0, 8'd1); #1;
        chk("bp_idle_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("bp1_a_ready", 32'(tl_o.a_ready), 32'd1);
        chk("bp1_req", 32'(req_o), 32'd1);
        cyc(); drive_a(3'd4, 2'd2, 32'h24, 4'hF, 32'h0, 8'd2); #1;
        chk("bp2_a_ready", 32'(tl_o.a_ready), 32'd1);
        chk("bp2_d_valid", 32'(tl_o.d_valid), 32'd1);
        chk("bp2_d_source", 32'(tl_o.d_source), 32'd1);
        chk("bp2_d_data", tl_o.d_data, 32'hC0DE0008);
        cyc(); drive_a(3'd4, 2'd2, 32'h28, 4'hF, 32'h0, 8'd3); #1;
        chk("bp3_a_ready", 32'(tl_o.a_ready), 32'd0);
        chk("bp3_req", 32'(req_o), 32'd0);
        chk("bp3_hold_source", 32'(tl_o.d_source), 32'd1);
        chk("bp3_hold_data", tl_o.d_data, 32'hC0DE0008);
        cyc(); #1;
        chk("bp4_a_ready", 32'(tl_o.a_ready), 32'd0);
        chk("bp4_hold_data", tl_o.d_data, 32'hC0DE0008);
        cyc(); tl_i.a_valid = 1'b0; tl_i.d_ready = 1'b1; #1;
        chk("bp_rsp1_valid", 32'(tl_o.d_valid), 32'd1);
        chk("bp_rsp1_source", 32'(tl_o.d_source), 32'd1);
        chk("bp_rsp1_data", tl_o.d_data, 32'hC0DE0008);
        cyc(); #1;
        chk("bp_rsp2_valid", 32'(tl_o.d_valid), 32'd1);
        chk("bp_rsp2_source", 32'(tl_o.d_source), 32'd2);
        chk("bp_rsp2_data", tl_o.d_data, 32'hC0DE0009);

        // Ten back-to-back Gets, words 16..25
        for (int k = 0; k <= 10; k++) begin
            cyc();
            if (k < 10) drive_a(3'd4, 2'd2, 32'h40 + 32'(4 * k), 4'hF, 32'h0, 8'(k));
            else        tl_i.a_valid = 1'b0;
            #1;
            if (k < 10) begin
                chk($sformatf("b2b%0d_a_ready", k), 32'(tl_o.a_ready), 32'd1);
                chk($sformatf("b2b%0d_req", k), 32'(req_o), 32'd1);
            end
            if (k == 0) begin
                chk("b2b0_d_valid", 32'(tl_o.d_valid), 32'd0);
            end else begin
                chk($sformatf("b2b%0d_d_valid", k), 32'(tl_o.d_valid), 32'd1);
                chk($sformatf("b2b%0d_d_source", k), 32'(tl_o.d_source), 32'(k - 1));
                chk($sformatf("b2b%0d_d_data", k), tl_o.d_data, 32'hC0DE0000 | 32'(16 + k - 1));
            end
        end
        cyc(); #1;
        chk("b2b_drained", 32'(tl_o.d_valid), 32'd0);

        // Reset with two entries outstanding
        tl_i.d_ready = 1'b0;
        drive_a(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd4);
        cyc(); drive_a(3'd4, 2'd2, 32'h34, 4'hF, 32'h0, 8'd5);
        cyc(); tl_i.a_valid = 1'b0; #1;
        chk("mid_full_a_ready", 32'(tl_o.a_ready), 32'd0);
        chk("mid_d_valid", 32'(tl_o.d_valid), 32'd1);
        rst_i = 1'b1;
        drive_a(3'd4, 2'd2, 32'h38, 4'hF, 32'h0, 8'd6);
        #1;
        chk("mid_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("mid_rst_a_ready", 32'(tl_o.a_ready), 32'd0);
        chk("mid_rst_req", 32'(req_o), 32'd0);
        cyc();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("mid_post_a_ready", 32'(tl_o.a_ready), 32'd1);
        chk("mid_post_d_valid", 32'(tl_o.d_valid), 32'd0);
        tl_i.d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk($sformatf("mid_stale%0d", k), 32'(tl_o.d_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
